// File: rtl/turn_scheduler_pkg.sv
// Shared game constants: FSM state encodings, timeout default and player-count limits.
package turn_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitFlip = 3'd1,
        StEval     = 3'd2,
        StAdvance  = 3'd3,
        StCheck    = 3'd4,
        StPass     = 3'd5,
        StGameOver = 3'd6
    } state_e;

    localparam int unsigned DefaultTurnTimeout = 1000;
    localparam int unsigned MinTurnTimeout     = 2;
    localparam int unsigned MinPlayers         = 2;
    localparam int unsigned MaxPlayers         = 4;

endpackage

// File: rtl/turn_scheduler_edge_detect.sv
// One-bit rising-edge detector: registered copy of the input, edge = d & ~d_q.
module turn_scheduler_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic edge_o
);

    logic d_q;

    // Delay the level by one cycle for comparison.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign edge_o = d_i & ~d_q;

endmodule

// File: rtl/turn_scheduler.sv
// Turn scheduler for the card game: rotates players, times out idle turns,
// strobes the position tracker on a matching flip and latches the winner.
module turn_scheduler
    import turn_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = MaxPlayers,
    parameter int unsigned TURN_TIMEOUT = DefaultTurnTimeout
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       flip_i,
    input  logic       card_match_i,
    input  logic       win_i,
    output logic [1:0] turn_o,
    output logic       adv_o,
    output logic       game_rst_n_o,
    output logic       game_over_o,
    output logic [1:0] winner_o,
    output logic [7:0] turn_count_o,
    output logic [2:0] state_o
);

    localparam int unsigned TimerW = $clog2(TURN_TIMEOUT);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TURN_TIMEOUT - 1);
    localparam logic [1:0] LastTurn = 2'(NUM_PLAYERS - 1);

    if (NUM_PLAYERS < MinPlayers || NUM_PLAYERS > MaxPlayers) begin : g_bad_players
        $error("NUM_PLAYERS must be within 2..4");
    end
    if (TURN_TIMEOUT < MinTurnTimeout) begin : g_bad_timeout
        $error("TURN_TIMEOUT must be at least 2");
    end

    logic flip_edge, start_edge;

    turn_scheduler_edge_detect u_flip_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (flip_i),
        .edge_o (flip_edge)
    );

    turn_scheduler_edge_detect u_start_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (start_i),
        .edge_o (start_edge)
    );

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]        turn_q, turn_d;
    logic [1:0]        winner_q, winner_d;
    logic [7:0]        count_q, count_d;
    logic              adv_q, adv_d;
    logic              game_rst_n_q, game_rst_n_d;
    logic              game_over_q, game_over_d;

    // Next-state logic; flag outputs are derived from the next state so they stay registered.
    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        turn_d   = turn_q;
        winner_d = winner_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle, StGameOver: begin
                if (start_edge) begin
                    state_d  = StWaitFlip;
                    turn_d   = 2'd0;
                    count_d  = 8'd0;
                    winner_d = 2'd0;
                end
            end
            StWaitFlip: begin
                // A flip in the timeout cycle wins over the timeout.
                if (flip_edge) begin
                    state_d = StEval;
                end else if (timer_q == TimerLast) begin
                    state_d = StPass;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StEval:    state_d = card_match_i ? StAdvance : StPass;
            StAdvance: state_d = StCheck;
            StCheck: begin
                if (win_i) begin
                    state_d  = StGameOver;
                    winner_d = turn_q;
                end else begin
                    state_d = StWaitFlip;
                end
            end
            StPass: begin
                state_d = StWaitFlip;
                turn_d  = (turn_q == LastTurn) ? 2'd0 : turn_q + 2'd1;
                count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            end
            default: state_d = StIdle;
        endcase

        adv_d        = (state_d == StAdvance);
        game_over_d  = (state_d == StGameOver);
        game_rst_n_d = !(((state_q == StIdle) || (state_q == StGameOver)) && start_edge);
    end

    // State and registered outputs; reset aborts any game immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            turn_q       <= 2'd0;
            winner_q     <= 2'd0;
            count_q      <= 8'd0;
            adv_q        <= 1'b0;
            game_rst_n_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            turn_q       <= turn_d;
            winner_q     <= winner_d;
            count_q      <= count_d;
            adv_q        <= adv_d;
            game_rst_n_q <= game_rst_n_d;
            game_over_q  <= game_over_d;
        end
    end

    assign turn_o       = turn_q;
    assign adv_o        = adv_q;
    assign game_rst_n_o = game_rst_n_q;
    assign game_over_o  = game_over_q;
    assign winner_o     = winner_q;
    assign turn_count_o = count_q;
    assign state_o      = state_q;

endmodule
